// File: rtl/writeback_stage.sv
// ============================================================================
//  Module      : writeback_stage
//  Description : MEM/WB pipeline register and register-file write port.
//                Captures one entry per cycle, selects load data or ALU
//                result as write data, and drives the decode register file.
//                Optional macro WB_RETIRE_COUNT_EN adds a 32-bit
//                retired-instruction counter and the retireCount port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module writeback_stage #(
  parameter int ZERO_GUARD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        validIn,
  input  logic        RegWriteIn,
  input  logic        MemtoRegIn,
  input  logic [31:0] ReadDataIn,
  input  logic [31:0] ALUResultIn,
  input  logic [4:0]  WriteRegIn,
  output logic        RegWrite,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteData,
`ifdef WB_RETIRE_COUNT_EN
  output logic [31:0] retireCount,
`endif
  output logic        validOut
);

  // MEM/WB pipeline register contents
  logic        r_valid;
  logic        r_regWrite;
  logic        r_memtoReg;
  logic [31:0] r_readData;
  logic [31:0] r_aluResult;
  logic [4:0]  r_writeReg;

  logic        w_destNonZero;
  logic        w_guardOk;

  // Valid bit: flush forces a bubble even while stalled; stall otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_valid <= validIn;
    end
  end

  // Payload fields: load whenever not stalled, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_regWrite  <= 1'b0;
      r_memtoReg  <= 1'b0;
      r_readData  <= 32'd0;
      r_aluResult <= 32'd0;
      r_writeReg  <= 5'd0;
    end else if (!stall) begin
      r_regWrite  <= RegWriteIn;
      r_memtoReg  <= MemtoRegIn;
      r_readData  <= ReadDataIn;
      r_aluResult <= ALUResultIn;
      r_writeReg  <= WriteRegIn;
    end
  end

  // Register-file write port, driven straight from the held entry. A stalled
  // entry keeps RegWrite high; rewriting the same value is harmless.
  always_comb begin
    w_destNonZero = |r_writeReg;
    w_guardOk     = (ZERO_GUARD == 0) || w_destNonZero;
    RegWrite      = r_valid & r_regWrite & w_guardOk;
    WriteReg      = r_writeReg;
    WriteData     = r_memtoReg ? r_readData : r_aluResult;
    validOut      = r_valid;
  end

`ifdef WB_RETIRE_COUNT_EN
  logic        w_retire;
  logic [31:0] r_retireCount;

  // An entry leaves WB (retires) when it is valid and the stage advances,
  // or when a flush pushes a bubble in behind it. Held cycles do not count.
  always_comb begin
    w_retire = r_valid & (~stall | flush);
  end

  // Retired-instruction counter, wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retireCount <= 32'd0;
    end else if (w_retire) begin
      r_retireCount <= r_retireCount + 32'd1;
    end
  end

  assign retireCount = r_retireCount;
`endif

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// ============================================================================
//  Module      : tb_writeback_stage
//  Description : Directed self-checking bench for writeback_stage. Counter
//                checks are compiled only with WB_RETIRE_COUNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, validIn, RegWriteIn, MemtoRegIn;
  logic [31:0] ReadDataIn, ALUResultIn;
  logic [4:0]  WriteRegIn;

  logic        RegWrite, validOut;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        RegWrite0, validOut0;
  logic [4:0]  WriteReg0;
  logic [31:0] WriteData0;
`ifdef WB_RETIRE_COUNT_EN
  logic [31:0] retireCount, retireCount0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_stage #(.ZERO_GUARD(1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .validIn(validIn),
    .RegWriteIn(RegWriteIn), .MemtoRegIn(MemtoRegIn), .ReadDataIn(ReadDataIn),
    .ALUResultIn(ALUResultIn), .WriteRegIn(WriteRegIn),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
`ifdef WB_RETIRE_COUNT_EN
    .retireCount(retireCount),
`endif
    .validOut(validOut)
  );

  writeback_stage #(.ZERO_GUARD(0)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .validIn(validIn),
    .RegWriteIn(RegWriteIn), .MemtoRegIn(MemtoRegIn), .ReadDataIn(ReadDataIn),
    .ALUResultIn(ALUResultIn), .WriteRegIn(WriteRegIn),
    .RegWrite(RegWrite0), .WriteReg(WriteReg0), .WriteData(WriteData0),
`ifdef WB_RETIRE_COUNT_EN
    .retireCount(retireCount0),
`endif
    .validOut(validOut0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r,
                       input logic [31:0] rd, input logic [31:0] alu,
                       input logic [4:0] wr);
    validIn = v; RegWriteIn = rw; MemtoRegIn = m2r;
    ReadDataIn = rd; ALUResultIn = alu; WriteRegIn = wr;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b1; flush = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 32'h1234_5678, 32'h8765_4321, 5'd17);
    step();
    step();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite: got %0b want 0", RegWrite); end
    checks++; if (WriteReg !== 5'd0) begin errors++; $display("FAIL reset_writereg: got %0d want 0", WriteReg); end
    checks++; if (WriteData !== 32'd0) begin errors++; $display("FAIL reset_writedata: got %h want 0", WriteData); end
    checks++; if (validOut !== 1'b0) begin errors++; $display("FAIL reset_validout: got %0b want 0", validOut); end
`ifdef WB_RETIRE_COUNT_EN
    checks++; if (retireCount !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", retireCount); end
`endif
    rst = 1'b0; stall = 1'b0;
  endtask

  task automatic test_alu();
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_0000, 32'h0000_00A5, 5'd8);
    step();
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL alu_regwrite: got %0b want 1", RegWrite); end
    checks++; if (WriteReg !== 5'd8) begin errors++; $display("FAIL alu_writereg: got %0d want 8", WriteReg); end
    checks++; if (WriteData !== 32'h0000_00A5) begin errors++; $display("FAIL alu_writedata: got %h want 000000a5", WriteData); end
    checks++; if (validOut !== 1'b1) begin errors++; $display("FAIL alu_validout: got %0b want 1", validOut); end
  endtask

  task automatic test_load();
    drive(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_1000, 5'd9);
    step();
    checks++; if (WriteData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_writedata: got %h want deadbeef", WriteData); end
    checks++; if (WriteReg !== 5'd9) begin errors++; $display("FAIL load_writereg: got %0d want 9", WriteReg); end
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL load_regwrite: got %0b want 1", RegWrite); end
  endtask

  task automatic test_zero_guard();
    drive(1'b1, 1'b1, 1'b0, 32'd0, 32'h0000_0777, 5'd0);
    step();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL zg1_regwrite: got %0b want 0", RegWrite); end
    checks++; if (validOut !== 1'b1) begin errors++; $display("FAIL zg1_validout: got %0b want 1", validOut); end
    checks++; if (RegWrite0 !== 1'b1) begin errors++; $display("FAIL zg0_regwrite: got %0b want 1", RegWrite0); end
    // Non-writing instruction: valid but no register write
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'h0000_0001, 5'd4);
    step();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL norw_regwrite: got %0b want 0", RegWrite); end
    checks++; if (validOut !== 1'b1) begin errors++; $display("FAIL norw_validout: got %0b want 1", validOut); end
  endtask

  task automatic test_stall();
`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] c0;
`endif
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_0055, 5'd5);
    step();
`ifdef WB_RETIRE_COUNT_EN
    c0 = retireCount;
`endif
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(i[0], 1'b1, 1'b1, 32'hA000_0000 + i, 32'hB000_0000 + i, 5'(10 + i));
      step();
      checks++; if (WriteReg !== 5'd5) begin errors++; $display("FAIL stall_writereg[%0d]: got %0d want 5", i, WriteReg); end
      checks++; if (WriteData !== 32'h0000_0055) begin errors++; $display("FAIL stall_writedata[%0d]: got %h want 00000055", i, WriteData); end
      checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL stall_regwrite[%0d]: got %0b want 1", i, RegWrite); end
    end
`ifdef WB_RETIRE_COUNT_EN
    checks++; if (retireCount !== c0) begin errors++; $display("FAIL stall_count_hold: got %0d want %0d", retireCount, c0); end
`endif
    stall = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    step();
    checks++; if (validOut !== 1'b0) begin errors++; $display("FAIL stall_release_validout: got %0b want 0", validOut); end
`ifdef WB_RETIRE_COUNT_EN
    checks++; if (retireCount !== c0 + 32'd1) begin errors++; $display("FAIL stall_count_once: got %0d want %0d", retireCount, c0 + 32'd1); end
`endif
  endtask

  task automatic test_flush();
    flush = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'd0, 32'h0000_0033, 5'd3);
    step();
    checks++; if (validOut !== 1'b0) begin errors++; $display("FAIL flush_validout: got %0b want 0", validOut); end
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL flush_regwrite: got %0b want 0", RegWrite); end
    flush = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'd0, 32'h0000_0044, 5'd6);
    step();
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL preflush_regwrite: got %0b want 1", RegWrite); end
    flush = 1'b1; stall = 1'b1;
    step();
    checks++; if (validOut !== 1'b0) begin errors++; $display("FAIL flushstall_validout: got %0b want 0", validOut); end
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL flushstall_regwrite: got %0b want 0", RegWrite); end
    flush = 1'b0; stall = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] alu [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    logic [31:0] rd  [4] = '{32'h9999_0001, 32'h9999_0002, 32'h9999_0003, 32'h9999_0004};
    logic        m2r [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [4:0]  wr  [4] = '{5'd1, 5'd31, 5'd16, 5'd2};
    logic [31:0] exp [4] = '{32'h1111_1111, 32'h9999_0002, 32'h9999_0003, 32'h4444_4444};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, m2r[i], rd[i], alu[i], wr[i]);
      step();
      checks++; if (WriteData !== exp[i]) begin errors++; $display("FAIL b2b_writedata[%0d]: got %h want %h", i, WriteData, exp[i]); end
      checks++; if (WriteReg !== wr[i]) begin errors++; $display("FAIL b2b_writereg[%0d]: got %0d want %0d", i, WriteReg, wr[i]); end
    end
  endtask

`ifdef WB_RETIRE_COUNT_EN
  task automatic test_wrap();
    drive(1'b1, 1'b1, 1'b0, 32'd0, 32'h0000_0010, 5'd12);
    step();
    force dut.r_retireCount = 32'hFFFF_FFFF;
    #1;
    release dut.r_retireCount;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    step();
    checks++; if (retireCount !== 32'd0) begin errors++; $display("FAIL wrap_count: got %h want 0", retireCount); end
  endtask
`endif

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 1'b0, 32'd0, 32'h0000_0099, 5'd7);
    step();
    rst = 1'b1; stall = 1'b1;
    step();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL rstmid_regwrite: got %0b want 0", RegWrite); end
    checks++; if (validOut !== 1'b0) begin errors++; $display("FAIL rstmid_validout: got %0b want 0", validOut); end
    checks++; if (WriteData !== 32'd0) begin errors++; $display("FAIL rstmid_writedata: got %h want 0", WriteData); end
`ifdef WB_RETIRE_COUNT_EN
    checks++; if (retireCount !== 32'd0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", retireCount); end
`endif
    rst = 1'b0; stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    test_reset();
    test_alu();
    test_load();
    test_zero_guard();
    test_stall();
    test_flush();
    test_back_to_back();
`ifdef WB_RETIRE_COUNT_EN
    test_wrap();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
